// File: rtl/i2c_target_pkg.sv
// Shared constants for the I2C target array: default parameters and channel FSM state encoding.
package i2c_target_pkg;

   localparam int             DEF_NUM_I2C_BUSSES = 1;
   localparam int             DEF_ADDR_WIDTH     = 7;
   localparam int             DEF_DATA_WIDTH     = 8;
   localparam int             DEF_MEM_DEPTH      = 16;
   localparam logic [6:0]     DEF_BASE_ADDR      = 7'h22;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_ADDR      = 4'd1;
   localparam state_t ST_ADDR_ACK  = 4'd2;
   localparam state_t ST_PTR       = 4'd3;
   localparam state_t ST_PTR_ACK   = 4'd4;
   localparam state_t ST_WDATA     = 4'd5;
   localparam state_t ST_WDATA_ACK = 4'd6;
   localparam state_t ST_RDATA     = 4'd7;
   localparam state_t ST_RACK      = 4'd8;
   localparam state_t ST_WAIT_STOP = 4'd9;

endpackage

// File: rtl/i2c_target_chan.sv
// One I2C target channel: synchronised bus inputs, protocol FSM and a small byte memory.
//
// state        | meaning
// IDLE         | bus free or unaddressed; wait for START
// ADDR         | shifting in address + R/W
// ADDR_ACK     | driving ACK for our address
// PTR          | shifting in memory pointer byte
// PTR_ACK      | driving ACK for pointer byte
// WDATA        | shifting in write data byte
// WDATA_ACK    | driving ACK for write data byte
// RDATA        | shifting out mem[ptr], MSB first
// RACK         | SDA released; sample master ACK/NACK
// WAIT_STOP    | not addressed or read ended; ignore bus until START/STOP
module i2c_target_chan
   import i2c_target_pkg::*;
#(
   parameter int                        I2C_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                        I2C_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                        MEM_DEPTH      = DEF_MEM_DEPTH,
   parameter logic [I2C_ADDR_WIDTH-1:0] CHAN_ADDR      = DEF_BASE_ADDR
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic busy_o,
   output logic done_o
);

   localparam int AW = I2C_ADDR_WIDTH;
   localparam int DW = I2C_DATA_WIDTH;
   localparam int PW = $clog2(MEM_DEPTH);
   localparam int CW = $clog2(DW);

   logic          scl_s1, scl_s2, scl_d;
   logic          sda_s1, sda_s2, sda_d;
   logic          scl_rise, scl_fall, start_det, stop_det;

   state_t        state, ack_next;
   logic [CW-1:0] bit_cnt;
   logic [DW-2:0] rx_sr;
   logic [DW-1:0] rx_byte;
   logic [DW-1:0] tx_sr;
   logic [PW-1:0] ptr, ptr_inc;
   logic          ack_phase, matched;
   logic          last_bit, addr_hit, read_start, mem_we;
   logic [DW-1:0] mem_rd;
   logic [DW-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_d  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_s1 <= scl_i;
         scl_s2 <= scl_s1;
         scl_d  <= scl_s2;
         sda_s1 <= sda_i;
         sda_s2 <= sda_s1;
         sda_d  <= sda_s2;
      end
   end

   assign scl_rise  =  scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 &  scl_d;
   assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
   assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

   // rx_sr holds the first DW-1 bits; the last bit is taken straight from the synchroniser
   assign rx_byte    = {rx_sr, sda_s2};
   assign last_bit   = (bit_cnt == CW'(DW - 1));
   assign addr_hit   = (rx_byte[AW:1] == CHAN_ADDR);
   assign ptr_inc    = ptr + PW'(1);
   assign mem_rd     = mem[ptr];
   assign read_start = (state == ST_ADDR_ACK) & rx_sr[0];
   assign mem_we     = (state == ST_WDATA) & scl_rise & last_bit;

   always_comb begin
      ack_next = ST_WDATA;
      case (state)
         ST_ADDR_ACK: ack_next = rx_sr[0] ? ST_RDATA : ST_PTR;
         default:     ack_next = ST_WDATA;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[ptr] <= rx_byte;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         ptr       <= '0;
         ack_phase <= 1'b0;
         matched   <= 1'b0;
         sda_o     <= 1'b1;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (start_det) begin
            state     <= ST_ADDR;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            sda_o     <= 1'b1;
            busy_o    <= 1'b1;
         end else if (stop_det) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            sda_o     <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= matched;
            matched   <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  rx_sr   <= rx_byte[DW-2:0];
                  bit_cnt <= bit_cnt + CW'(1);
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (addr_hit) begin
                        matched <= 1'b1;
                        state   <= ST_ADDR_ACK;
                     end else begin
                        state   <= ST_WAIT_STOP;
                     end
                  end
               end
               ST_PTR: if (scl_rise) begin
                  rx_sr   <= rx_byte[DW-2:0];
                  bit_cnt <= bit_cnt + CW'(1);
                  if (last_bit) begin
                     bit_cnt <= '0;
                     ptr     <= rx_byte[PW-1:0];
                     state   <= ST_PTR_ACK;
                  end
               end
               ST_WDATA: if (scl_rise) begin
                  rx_sr   <= rx_byte[DW-2:0];
                  bit_cnt <= bit_cnt + CW'(1);
                  if (last_bit) begin
                     bit_cnt <= '0;
                     ptr     <= ptr_inc;
                     state   <= ST_WDATA_ACK;
                  end
               end
               // first fall after the byte pulls SDA low, second fall ends the ACK slot
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_o     <= 1'b0;
                     ack_phase <= 1'b1;
                  end else begin
                     ack_phase <= 1'b0;
                     state     <= ack_next;
                     if (read_start) begin
                        sda_o <= mem_rd[DW-1];
                        tx_sr <= {mem_rd[DW-2:0], 1'b0};
                     end else begin
                        sda_o <= 1'b1;
                     end
                  end
               end
               ST_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + CW'(1);
                     if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= ST_RACK;
                     end
                  end else if (scl_fall) begin
                     // bit_cnt==0 here only after a master ACK: start the next byte
                     if (bit_cnt == '0) begin
                        sda_o <= mem_rd[DW-1];
                        tx_sr <= {mem_rd[DW-2:0], 1'b0};
                     end else begin
                        sda_o <= tx_sr[DW-1];
                        tx_sr <= {tx_sr[DW-2:0], 1'b0};
                     end
                  end
               end
               ST_RACK: begin
                  if (scl_fall) begin
                     sda_o <= 1'b1;
                  end else if (scl_rise) begin
                     if (!sda_s2) begin
                        ptr   <= ptr_inc;
                        state <= ST_RDATA;
                     end else begin
                        state <= ST_WAIT_STOP;
                     end
                  end
               end
               ST_IDLE, ST_WAIT_STOP: sda_o <= 1'b1;
               default: begin
                  state <= ST_IDLE;
                  sda_o <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/i2c_target_array.sv
// Array of independent I2C target channels; channel n answers at BASE_ADDR+n.
module i2c_target_array
   import i2c_target_pkg::*;
#(
   parameter int                        NUM_I2C_BUSSES = DEF_NUM_I2C_BUSSES,
   parameter int                        I2C_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                        I2C_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                        MEM_DEPTH      = DEF_MEM_DEPTH,
   parameter logic [I2C_ADDR_WIDTH-1:0] BASE_ADDR      = DEF_BASE_ADDR
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_I2C_BUSSES-1:0] scl_i,
   input  logic [NUM_I2C_BUSSES-1:0] sda_i,
   output logic [NUM_I2C_BUSSES-1:0] sda_o,
   output logic [NUM_I2C_BUSSES-1:0] busy_o,
   output logic [NUM_I2C_BUSSES-1:0] done_o
);

   for (genvar g = 0; g < NUM_I2C_BUSSES; g++) begin : g_chan
      // address arithmetic wraps naturally at the address width
      localparam logic [I2C_ADDR_WIDTH-1:0] CHAN_ADDR = BASE_ADDR + I2C_ADDR_WIDTH'(g);

      i2c_target_chan #(
         .I2C_ADDR_WIDTH (I2C_ADDR_WIDTH),
         .I2C_DATA_WIDTH (I2C_DATA_WIDTH),
         .MEM_DEPTH      (MEM_DEPTH),
         .CHAN_ADDR      (CHAN_ADDR)
      ) u_chan (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .scl_i  (scl_i[g]),
         .sda_i  (sda_i[g]),
         .sda_o  (sda_o[g]),
         .busy_o (busy_o[g]),
         .done_o (done_o[g])
      );
   end

endmodule

// File: doc/i2c_target_array.md
I2C_TARGET_ARRAY -- requirements
Module: i2c_target_array

Interface
REQ-001 SHALL have parameter NUM_I2C_BUSSES, default 1, number of independent I2C target channels.
REQ-002 SHALL have parameter I2C_ADDR_WIDTH, default 7, target address width.
REQ-003 SHALL have parameter I2C_DATA_WIDTH, default 8, byte width.
REQ-004 SHALL have parameter MEM_DEPTH, default 16, bytes per channel; power of two, 2..256.
REQ-005 SHALL have parameter BASE_ADDR, default 7'h22; channel n responds at BASE_ADDR+n, modulo 2^I2C_ADDR_WIDTH.
REQ-006 SHALL have port clk_i, input, 1, system clock; one clock domain.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port scl_i, input, NUM_I2C_BUSSES, bus clock per channel.
REQ-009 SHALL have port sda_i, input, NUM_I2C_BUSSES, bus data per channel.
REQ-010 SHALL have port sda_o, output, NUM_I2C_BUSSES, open-drain drive: 0 pulls low, 1 releases.
REQ-011 SHALL have port busy_o, output, NUM_I2C_BUSSES, high from START until STOP.
REQ-012 SHALL have port done_o, output, NUM_I2C_BUSSES, one-cycle pulse on STOP after an addressed transfer.

Function
REQ-013 SHALL pass scl_i/sda_i through 2-flop synchronisers, then edge-detect; 3-cycle input latency.
REQ-014 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high; both override any state.
REQ-015 SHALL sample SDA on SCL rising edges and change sda_o only on the cycle after an SCL falling edge.
REQ-016 SHALL implement per-channel FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
REQ-017 SHALL go to ADDR on START or repeated START, bit counter cleared, from any state.
REQ-018 SHALL, in ADDR after 8 bits, ACK (drive 0 for one SCL period) if the address matches, else release SDA and go to WAIT_STOP.
REQ-019 SHALL, on R/W=0, go PTR; the received byte, modulo MEM_DEPTH, loads the pointer, then ACK, then WDATA.
REQ-020 SHALL, in WDATA, write each byte to mem[ptr] after the 8th bit, ACK it, and increment ptr with wrap MEM_DEPTH-1 -> 0.
REQ-021 SHALL, on R/W=1, go RDATA and shift out mem[ptr] MSB first, then release SDA in RACK.
REQ-022 SHALL, in RACK, increment ptr (wrap) and continue RDATA on master ACK (0); on NACK (1), go WAIT_STOP.
REQ-023 SHALL keep the pointer across repeated START, so write-pointer-then-read works.
REQ-024 SHALL go to IDLE on STOP, deassert busy_o and pulse done_o if address was matched.
REQ-025 SHALL never drive sda_o low in IDLE or WAIT_STOP, or during a master-driven bit.
REQ-026 SHALL keep channels fully independent; simultaneous transfers on all buses are legal.

Reset
REQ-027 SHALL, on rst_i low, immediately set sda_o all 1, busy_o 0, done_o 0, FSM IDLE, ptr 0, synchroniser flops 1.
REQ-028 SHALL not reset memory contents.
REQ-029 SHALL, after reset release mid-transfer, ignore bus activity until the next START.

Structure
REQ-030 SHALL place the FSM state enum and default parameter constants in shared package i2c_target_pkg.
REQ-031 SHALL use sub-module i2c_target_chan for one channel, instantiated NUM_I2C_BUSSES times by a generate loop.

Verification
REQ-032 Write test: START, 0x44 (0x22 W), 0x03, 0xA5, 0x5A, STOP -> 4 ACKs, mem[3]=A5, mem[4]=5A, one done_o pulse.
REQ-033 Read test: START, 0x44, 0x03, rSTART, 0x45, master ACK then NACK, STOP -> bytes A5, 5A returned.
REQ-034 Mismatch test: START, 0x60 W -> SDA high at ACK slot, no memory change, no done_o.
REQ-035 Wrap test: pointer 0x0F, write 0x11, 0x22 -> mem[15]=11, mem[0]=22.
REQ-036 Reset test: rst_i low during a data byte -> sda_o=1 the same cycle; next transaction behaves as REQ-032.
REQ-037 Multi-bus test: NUM_I2C_BUSSES=2, concurrent writes to 0x22 on bus0 and 0x23 on bus1 -> both ACK and stores are independent.
